// File: rtl/pipe_stage_buf.sv
// Pipeline stage register between two valid/ready stages, with flush and bubble insertion.
// Define PIPE_STAGE_SKID_EN to build the two-entry registered-ready skid variant.
module pipe_stage_buf #(
    parameter int CTRL_W = 13,
    parameter int DATA_W = 134
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: a transfer happens on any rising edge where valid and ready are both 1;
    // valid never waits on ready, and a held entry stays unchanged until it transfers.

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_empty;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              out_free;
    logic              in_xfer;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready  = skid_empty;
    assign out_free  = ~out_valid | out_ready;
    assign in_xfer   = in_valid & skid_empty;
    assign occupancy = {1'b0, out_valid} + {1'b0, ~skid_empty};

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            skid_empty <= 1'b1;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_empty <= 1'b1;
        end else if (out_free) begin
            if (!skid_empty) begin
                out_valid  <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                skid_empty <= 1'b1;
            end else if (in_xfer) begin
                out_valid <= 1'b1;
                out_ctrl  <= in_ctrl;
                out_data  <= in_data;
            end else begin
                // Bubble: control cleared, data left as-is.
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end else if (in_xfer) begin
            // Output stalled: park the new entry behind it.
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_empty <= 1'b0;
        end
    end

`else

    assign in_ready  = ~out_valid | out_ready;
    assign occupancy = {1'b0, out_valid};

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_ctrl  <= in_valid ? in_ctrl : '0;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios plus a randomized run
// checked against a queue model of the buffer contents.
module tb_pipe_stage_buf;

    localparam int CTRL_W = 13;
    localparam int DATA_W = 134;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam logic       EXP_RDY_STALL = (CAP == 2);
    localparam logic [1:0] EXP_OCC_FULL  = 2'(CAP);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the ordered list of entries held in the buffer.
    logic [CTRL_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [DATA_W-1:0] last_data;

    pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clock    (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DATA_W-1:0];
    endfunction

    function automatic logic model_ready();
        if (CAP == 2) return exp_q.size() < 2;
        return (exp_q.size() == 0) || out_ready;
    endfunction

    function automatic logic model_valid();
        return exp_q.size() > 0;
    endfunction

    function automatic logic [CTRL_W-1:0] model_ctrl();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    task automatic drive(input logic rst, input logic iv, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        reset     = rst;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then
    // return at the falling edge where outputs are sampled.
    task automatic tick();
        logic rdy;
        rdy = model_ready();
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_data_q.delete();
            last_data = '0;
        end else if (flush) begin
            exp_q.delete();
            exp_data_q.delete();
        end else begin
            if (exp_q.size() > 0 && out_ready) begin
                void'(exp_q.pop_front());
                void'(exp_data_q.pop_front());
            end
            if (in_valid && rdy) begin
                exp_q.push_back(in_ctrl);
                exp_data_q.push_back(in_data);
            end
        end
        if (exp_data_q.size() > 0) last_data = exp_data_q[0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 13'h1FFF, rand_data(), 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", out_ctrl); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
    endtask

    logic [DATA_W-1:0] stream_last;

    task automatic test_stream();
        logic [DATA_W-1:0] d;
        for (int i = 1; i <= 3; i++) begin
            d = rand_data();
            drive(1'b0, 1'b1, CTRL_W'(i), d, 1'b1, 1'b0);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_rdy got %b want 1", in_ready); end
            tick();
            n_cmp++; if (out_ctrl !== CTRL_W'(i)) begin n_err++; $display("FAIL stream_ctrl got %0d want %0d", out_ctrl, i); end
            n_cmp++; if (out_data !== d) begin n_err++; $display("FAIL stream_data got %h want %h", out_data, d); end
            n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ got %0d want 1", occupancy); end
            stream_last = d;
        end
    endtask

    task automatic test_bubble();
        logic [DATA_W-1:0] d;
        drive(1'b0, 1'b0, 13'h0ABC, rand_data(), 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("FAIL bubble_ctrl got %h want 0", out_ctrl); end
        n_cmp++; if (out_data !== stream_last) begin n_err++; $display("FAIL bubble_data got %h want %h", out_data, stream_last); end
        d = rand_data();
        drive(1'b0, 1'b1, 13'd4, d, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_ctrl !== 13'd4) begin n_err++; $display("FAIL bubble_resume got %0d want 4", out_ctrl); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] da, db;
        da = rand_data();
        db = rand_data();
        drive(1'b0, 1'b1, 13'd5, da, 1'b0, 1'b0);
        tick();
        n_cmp++; if (out_ctrl !== 13'd5) begin n_err++; $display("FAIL stall_a got %0d want 5", out_ctrl); end
        drive(1'b0, 1'b1, 13'd6, db, 1'b0, 1'b0);
        #1;
        n_cmp++; if (in_ready !== EXP_RDY_STALL) begin n_err++; $display("FAIL stall_rdy_offer got %b want %b", in_ready, EXP_RDY_STALL); end
        tick();
        n_cmp++; if (out_ctrl !== 13'd5) begin n_err++; $display("FAIL stall_hold_ctrl got %0d want 5", out_ctrl); end
        n_cmp++; if (out_data !== da) begin n_err++; $display("FAIL stall_hold_data got %h want %h", out_data, da); end
        n_cmp++; if (occupancy !== EXP_OCC_FULL) begin n_err++; $display("FAIL stall_occ got %0d want %0d", occupancy, EXP_OCC_FULL); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_rdy_full got %b want 0", in_ready); end
        drive(1'b0, 1'b1, 13'd6, db, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_ctrl !== 13'd6) begin n_err++; $display("FAIL stall_b got %0d want 6", out_ctrl); end
        n_cmp++; if (out_data !== db) begin n_err++; $display("FAIL stall_b_data got %h want %h", out_data, db); end
        n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stall_b_occ got %0d want 1", occupancy); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stall_drain_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 13'd5, rand_data(), 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 13'd7, rand_data(), 1'b0, 1'b0);
        tick();
        n_cmp++; if (occupancy !== EXP_OCC_FULL) begin n_err++; $display("FAIL flush_pre_occ got %0d want %0d", occupancy, EXP_OCC_FULL); end
        drive(1'b0, 1'b1, 13'd9, rand_data(), 1'b0, 1'b1);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== '0) begin n_err++; $display("FAIL flush_ctrl got %h want 0", out_ctrl); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_cmp++; if (out_data !== last_data) begin n_err++; $display("FAIL flush_data got %h want %h", out_data, last_data); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
            tick();
            n_cmp++; if (out_valid !== 1'b0 || out_ctrl === 13'd9) begin n_err++; $display("FAIL flush_leak valid %b ctrl %0d want 0/0", out_valid, out_ctrl); end
        end
    endtask

    task automatic test_reset_stall();
        drive(1'b0, 1'b1, 13'd11, rand_data(), 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 13'd12, rand_data(), 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 13'd13, rand_data(), 1'b0, 1'b0);
        tick();
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_stall_occ got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stall_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_stall_data got %h want 0", out_data); end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stall_after got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        int accepted;
        int n_out;
        int cycles;
        logic iv, ordy, rdy;
        accepted = 0;
        n_out    = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(1'b0, iv, CTRL_W'($urandom), rand_data(), ordy, 1'b0);
            #1;
            rdy = model_ready();
            n_cmp++; if (in_ready !== rdy) begin n_err++; $display("FAIL rnd_rdy cyc %0d got %b want %b", cycles, in_ready, rdy); end
            if (iv && rdy) accepted++;
            if (out_valid && ordy) n_out++;
            tick();
            cycles++;
            n_cmp++; if (out_valid !== model_valid()) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", cycles, out_valid, model_valid()); end
            n_cmp++; if (out_ctrl !== model_ctrl()) begin n_err++; $display("FAIL rnd_ctrl cyc %0d got %h want %h", cycles, out_ctrl, model_ctrl()); end
            n_cmp++; if (out_data !== last_data) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", cycles, out_data, last_data); end
            n_cmp++; if (occupancy !== 2'(exp_q.size()) || int'(occupancy) > CAP) begin n_err++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", cycles, occupancy, exp_q.size()); end
        end
        n_cmp++; if (accepted != 1000) begin n_err++; $display("FAIL rnd_timeout accepted %0d want 1000", accepted); end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
            #1;
            if (out_valid) n_out++;
            tick();
        end
        n_cmp++; if (n_out != 1000) begin n_err++; $display("FAIL rnd_count outputs %0d want 1000", n_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drained got %b want 0", out_valid); end
    endtask

    initial begin
        last_data = '0;
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_bubble();
        test_stall();
        test_flush();
        test_reset_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
